pad_in_event_ctrl: RTL
======================

// Module: pad_in_event_ctrl
// PURPOSE
//  Conditions the C outputs of N_CH input pad cells: synchronises each to CLK,
//  debounces on a shared prescaled tick, and detects enabled edges.
//  Round-robin schedules pending edge events onto one valid/ready event port.
//  Sits between the pad ring and the core interrupt/status logic.
// PARAMETERS
//  N_CH        8    number of pad input channels (>=2)
//  SYNC_STAGES 2    synchroniser flops per channel (>=2)
//  DIV         100  CLK cycles per debounce sample tick (>=1; 1 = tick every cycle)
//  DB_CNT      4    consecutive differing ticks before LEVEL flips (>=1)
//  LEVEL_RST   0    reset value of every LEVEL bit
// PORTS
//  CLK       in   1                 core clock, rising edge
//  RSTN      in   1                 asynchronous reset, active-low
//  C_IN      in   N_CH              raw pad cell outputs, asynchronous to CLK
//  RISE_EN   in   N_CH              per-channel rising-edge event enable
//  FALL_EN   in   N_CH              per-channel falling-edge event enable
//  LEVEL     out  N_CH              debounced level per channel
//  PENDING   out  N_CH              event-pending flags
//  EVT_VALID out  1                 event offered
//  EVT_CH    out  $clog2(N_CH)      channel of offered event
//  EVT_RISE  out  1                 1 = rising, 0 = falling
//  EVT_READY in   1                 consumer accepts event
//  OVERRUN   out  1                 sticky: event lost on a still-pending channel
//  OVR_CLR   in   1                 synchronous clear of OVERRUN
// BEHAVIOUR
//  Reset (RSTN low, async): sync flops=LEVEL_RST, LEVEL=LEVEL_RST, counters=0,
//   prescaler=0, PENDING=0, EVT_VALID=0, EVT_CH=0, EVT_RISE=0, OVERRUN=0,
//   RR pointer=0. Reset mid-debounce or mid-handshake discards all state.
//  Prescaler counts 0..DIV-1; TICK is high the cycle it equals DIV-1, then wraps to 0.
//  Per channel, on TICK: if sync!=LEVEL, cnt++; cnt reaching DB_CNT flips LEVEL
//   and clears cnt. If sync==LEVEL, cnt clears. Between ticks cnt holds.
//  Latency: a clean step is seen at LEVEL after SYNC_STAGES cycles plus
//   DB_CNT ticks (worst case SYNC_STAGES + DB_CNT*DIV cycles).
//  Event: a LEVEL flip 0->1 with RISE_EN, or 1->0 with FALL_EN, sets PENDING[i]
//   and stores its direction. Enable is sampled in the flip cycle only.
//  If PENDING[i] is already set and not being accepted in that cycle: OVERRUN
//   goes to 1. The stored event is kept and the new one is dropped.
//  Scheduler FSM, two states:
//   IDLE: if any PENDING, pick the first set bit at or after the RR pointer
//    (with wrap), latch EVT_CH/EVT_RISE, go to OFFER. EVT_VALID=0 in IDLE.
//   OFFER: EVT_VALID=1 and EVT_CH/EVT_RISE are held stable until EVT_READY.
//    On VALID&READY: clear PENDING[EVT_CH], set RR pointer to EVT_CH+1
//    (wrap N_CH-1 -> 0), go to IDLE.
//   New event on EVT_CH in the same cycle as its acceptance: PENDING stays set
//    with the new direction, and no OVERRUN.
//   So there is at most one event per 2 cycles, and accept-to-next-VALID is 1 cycle.
//  OVR_CLR clears OVERRUN. A same-cycle new overrun wins, and OVERRUN stays 1.
//  Toggling enables never creates, cancels or alters already pending events.
// STRUCTURE
//  Shared package pad_pkg: sched_state_t enum {IDLE, OFFER}, and the function
//   rr_pick(pending, ptr) returning the channel index.
//  Sub-module pad_in_debounce: one channel (sync chain, counter, LEVEL, edge
//   pulses rise/fall), instantiated N_CH times via generate.
//  Top level holds the prescaler, PENDING/direction regs, FSM and OVERRUN.
// TESTING
//  DIV=1, DB_CNT=4: step C_IN[0] 0->1 with RISE_EN[0]=1 -> LEVEL[0] rises at
//   cycle 2+4. VALID=1 with CH=0, RISE=1 one cycle later.
//  Glitch of 3 cycles on C_IN[3] (DIV=1, DB_CNT=4) -> LEVEL[3] and PENDING unchanged.
//  Edges on ch 1, 5, 6 in one cycle, READY=1 -> events in order 1, 5, 6. Then
//   ch 1 and ch 6 again -> order 1, 6 after the pointer wrap.
//  READY held 0 while ch 2 toggles twice with RISE_EN/FALL_EN=1 -> first event
//   kept, OVERRUN=1. OVR_CLR pulse -> OVERRUN=0.
//  FALL_EN=0, RISE_EN=1: a falling step -> LEVEL falls, no PENDING. A rising step
//   -> event with RISE=1.
//  Assert RSTN low while VALID=1 and counters are mid-count -> all outputs at reset
//   values immediately. No event after release.

Source files
------------

// File: rtl/pad_pkg.sv
// Shared types and helpers for the pad input event controller.
package pad_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } sched_state_t;

  localparam int unsigned MAX_CH   = 32;
  localparam int unsigned MAX_CH_W = 5;

  // First set bit at or after ptr, wrapping at n_ch; returns 0 when nothing is set.
  function automatic int unsigned rr_pick(input logic [MAX_CH-1:0] pending,
                                          input int unsigned ptr,
                                          input int unsigned n_ch);
    int unsigned idx;
    rr_pick = 0;
    for (int k = MAX_CH - 1; k >= 0; k--) begin
      idx = ptr + 32'(k);
      if (idx >= n_ch) idx = idx - n_ch;
      if ((32'(k) < n_ch) && (idx < MAX_CH) && pending[idx[MAX_CH_W-1:0]]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/pad_in_event_ctrl_if.sv
// Valid/ready event port carrying channel index and edge direction.
interface pad_in_event_ctrl_if #(
  parameter int unsigned N_CH = 8
);
  localparam int unsigned CH_W = $clog2(N_CH);

  logic            evt_valid;
  logic [CH_W-1:0] evt_ch;
  logic            evt_rise;
  logic            evt_ready;

  modport master (output evt_valid, output evt_ch, output evt_rise, input evt_ready);
  modport slave  (input evt_valid, input evt_ch, input evt_rise, output evt_ready);
endinterface

// File: rtl/pad_in_debounce.sv
// One pad channel: synchroniser chain, tick-based debounce counter, debounced level
// and single-cycle flip indications aligned with the LEVEL update.
module pad_in_debounce #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_CNT      = 4,
  parameter bit          LEVEL_RST   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic c_in,
  input  logic tick,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  localparam int unsigned CNT_W = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   level_q;
  logic                   differ;
  logic                   flip;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {SYNC_STAGES{LEVEL_RST}};
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], c_in};
  end

  assign differ = sync_q[SYNC_STAGES-1] ^ level_q;
  assign flip   = tick & differ & (cnt_q == CNT_W'(DB_CNT - 1));

  // Counter only moves on ticks; any agreeing tick restarts the qualification.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      level_q <= LEVEL_RST;
    end else if (tick) begin
      if (!differ) begin
        cnt_q <= '0;
      end else if (flip) begin
        cnt_q   <= '0;
        level_q <= ~level_q;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign level  = level_q;
  assign rise_c = flip & ~level_q;
  assign fall_c = flip & level_q;

endmodule

// File: rtl/pad_in_event_ctrl.sv
// Pad input conditioning: per-channel sync + debounce, enabled edge capture into
// pending flags, and round-robin scheduling onto a single valid/ready event port.
module pad_in_event_ctrl
  import pad_pkg::*;
#(
  parameter int unsigned N_CH        = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DIV         = 100,
  parameter int unsigned DB_CNT      = 4,
  parameter bit          LEVEL_RST   = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_CH-1:0]      c_in,
  input  logic [N_CH-1:0]      rise_en,
  input  logic [N_CH-1:0]      fall_en,
  output logic [N_CH-1:0]      level,
  output logic [N_CH-1:0]      pending,
  output logic                 overrun,
  input  logic                 ovr_clr,
  pad_in_event_ctrl_if.master  evt
);

  localparam int unsigned CH_W  = $clog2(N_CH);
  localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PRE_W-1:0] pre_q;
  logic             tick;
  logic [N_CH-1:0]  rise_c;
  logic [N_CH-1:0]  fall_c;
  logic [N_CH-1:0]  new_evt;
  logic [N_CH-1:0]  acc_vec;
  logic             accept;

  logic [N_CH-1:0]  pending_q, pending_d;
  logic [N_CH-1:0]  dir_q, dir_d;
  logic             overrun_q, overrun_d;
  logic             ovr_set;

  sched_state_t     state_q, state_d;
  logic             evt_valid_q, evt_valid_d;
  logic [CH_W-1:0]  evt_ch_q, evt_ch_d;
  logic             evt_rise_q, evt_rise_d;
  logic [CH_W-1:0]  ptr_q, ptr_d;
  logic [CH_W-1:0]  pick_ch;

  // Shared debounce sample tick.
  assign tick = (pre_q == PRE_W'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pre_q <= '0;
    else if (tick) pre_q <= '0;
    else           pre_q <= pre_q + PRE_W'(1);
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    pad_in_debounce #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CNT      (DB_CNT),
      .LEVEL_RST   (LEVEL_RST)
    ) u_db (
      .clk    (clk),
      .rst_n  (rst_n),
      .c_in   (c_in[g]),
      .tick   (tick),
      .level  (level[g]),
      .rise_c (rise_c[g]),
      .fall_c (fall_c[g])
    );
  end

  assign new_evt = (rise_c & rise_en) | (fall_c & fall_en);
  assign accept  = (state_q == OFFER) & evt.evt_ready;
  assign acc_vec = accept ? (N_CH'(1) << evt_ch_q) : '0;

  // A slot being accepted this cycle may take a new event; otherwise it is dropped.
  always_comb begin
    pending_d = pending_q;
    dir_d     = dir_q;
    ovr_set   = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (new_evt[i] && (!pending_q[i] || acc_vec[i])) begin
        pending_d[i] = 1'b1;
        dir_d[i]     = rise_c[i];
      end else begin
        if (acc_vec[i]) pending_d[i] = 1'b0;
        if (new_evt[i]) ovr_set = 1'b1;
      end
    end
  end

  assign overrun_d = ovr_set ? 1'b1 : (ovr_clr ? 1'b0 : overrun_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      dir_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      dir_q     <= dir_d;
      overrun_q <= overrun_d;
    end
  end

  assign pick_ch = CH_W'(rr_pick(MAX_CH'(pending_q), 32'(ptr_q), N_CH));

  // Scheduler next-state and registered port values.
  always_comb begin
    state_d     = state_q;
    evt_valid_d = evt_valid_q;
    evt_ch_d    = evt_ch_q;
    evt_rise_d  = evt_rise_q;
    ptr_d       = ptr_q;
    case (state_q)
      IDLE: begin
        evt_valid_d = 1'b0;
        if (|pending_q) begin
          evt_ch_d    = pick_ch;
          evt_rise_d  = dir_q[pick_ch];
          evt_valid_d = 1'b1;
          state_d     = OFFER;
        end
      end
      OFFER: begin
        if (evt.evt_ready) begin
          evt_valid_d = 1'b0;
          ptr_d       = (evt_ch_q == CH_W'(N_CH - 1)) ? '0 : evt_ch_q + CH_W'(1);
          state_d     = IDLE;
        end
      end
      default: begin
        evt_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      evt_rise_q  <= 1'b0;
      ptr_q       <= '0;
    end else begin
      state_q     <= state_d;
      evt_valid_q <= evt_valid_d;
      evt_ch_q    <= evt_ch_d;
      evt_rise_q  <= evt_rise_d;
      ptr_q       <= ptr_d;
    end
  end

  assign pending       = pending_q;
  assign overrun       = overrun_q;
  assign evt.evt_valid = evt_valid_q;
  assign evt.evt_ch    = evt_ch_q;
  assign evt.evt_rise  = evt_rise_q;

endmodule
